// File: rtl/alu_cluster_pkg.sv
// Shared opcode and flag definitions for the integer ALU cluster.
package alu_cluster_pkg;

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_AND = 8'h03;
    localparam logic [7:0] OP_OR  = 8'h04;
    localparam logic [7:0] OP_XOR = 8'h05;
    localparam logic [7:0] OP_SHL = 8'h06;
    localparam logic [7:0] OP_SHR = 8'h07;
    localparam logic [7:0] OP_SAR = 8'h08;
    localparam logic [7:0] OP_MUL = 8'h09;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_S = 2;
    localparam int FLG_O = 3;

    function automatic logic [3:0] mk_flg(input logic o, input logic s, input logic z, input logic c);
        logic [3:0] f;
        f        = '0;
        f[FLG_O] = o;
        f[FLG_S] = s;
        f[FLG_Z] = z;
        f[FLG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/alu_lane.sv
// One ALU lane: issue register, operand forwarding mux, single-cycle ALU, result register.
// The lane that shares its port with the multiplier exports its muxed operands for MUL.
module alu_lane
    import alu_cluster_pkg::*;
#(
    parameter int W       = 64,
    parameter int NFWD    = 10,
    parameter int RW      = 9,
    parameter bit HAS_MUL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              except,
    input  logic              in_vld,
    input  logic [7:0]        in_op,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    input  logic [RW-1:0]     in_tag,
    input  logic [NFWD-1:0]   a_fwd,
    input  logic [NFWD-1:0]   b_fwd,
    input  logic [NFWD-1:0]   a_fwdr,
    input  logic [NFWD-1:0]   b_fwdr,
    input  logic [NFWD*W-1:0] fwd_bus,
    input  logic [NFWD*W-1:0] fwd_bus_r,
    input  logic              kill,
    output logic              res_vld,
    output logic [W-1:0]      res_data,
    output logic [3:0]        res_flg,
    output logic [RW-1:0]     res_tag,
    output logic              simple_vld,
    output logic              mul_vld,
    output logic [W-1:0]      opa,
    output logic [W-1:0]      opb,
    output logic [RW-1:0]     tag
);

    localparam int SW = $clog2(W);

    logic              s1_vld;
    logic [7:0]        s1_op;
    logic [W-1:0]      s1_a, s1_b;
    logic [RW-1:0]     s1_tag;
    logic [NFWD-1:0]   s1_afwd, s1_bfwd, s1_afwdr, s1_bfwdr;

    logic              is_mul;
    logic [W-1:0]      alu_r;
    logic [W:0]        ext;
    logic              alu_c, alu_o, known;
    logic [SW-1:0]     sh;

    // Current-cycle bus select has priority over the registered bus select.
    function automatic logic [W-1:0] pick(input logic [W-1:0] rr, input logic [NFWD-1:0] cur,
                                          input logic [NFWD-1:0] prev, input logic [NFWD*W-1:0] bus,
                                          input logic [NFWD*W-1:0] bus_r);
        logic [W-1:0] v;
        v = '0;
        if (|cur) begin
            for (int i = 0; i < NFWD; i++)
                if (cur[i]) v = v | bus[i*W +: W];
        end else if (|prev) begin
            for (int i = 0; i < NFWD; i++)
                if (prev[i]) v = v | bus_r[i*W +: W];
        end else begin
            v = rr;
        end
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
            s1_afwd  <= '0;
            s1_bfwd  <= '0;
            s1_afwdr <= '0;
            s1_bfwdr <= '0;
            res_vld  <= 1'b0;
            res_data <= '0;
            res_flg  <= '0;
            res_tag  <= '0;
        end else begin
            s1_vld   <= in_vld & ~except;
            s1_op    <= in_op;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_tag   <= in_tag;
            s1_afwd  <= a_fwd;
            s1_bfwd  <= b_fwd;
            s1_afwdr <= a_fwdr;
            s1_bfwdr <= b_fwdr;
            res_vld  <= simple_vld & ~kill & ~except;
            res_data <= known ? alu_r : '0;
            res_flg  <= known ? mk_flg(alu_o, alu_r[W-1], alu_r == '0, alu_c) : 4'h0;
            res_tag  <= s1_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && s1_vld) begin
            fwd_sel_onehot: assert ($onehot0(s1_afwd) && $onehot0(s1_bfwd) &&
                                    $onehot0(s1_afwdr) && $onehot0(s1_bfwdr));
        end
    end

    assign opa        = pick(s1_a, s1_afwd, s1_afwdr, fwd_bus, fwd_bus_r);
    assign opb        = pick(s1_b, s1_bfwd, s1_bfwdr, fwd_bus, fwd_bus_r);
    assign tag        = s1_tag;
    assign is_mul     = HAS_MUL && (s1_op == OP_MUL);
    assign simple_vld = s1_vld & ~is_mul;
    assign mul_vld    = s1_vld & is_mul;
    assign sh         = opb[SW-1:0];

    // Shifts run one bit wider so the last bit shifted out lands in ext's spare bit.
    always_comb begin
        alu_r = '0;
        ext   = '0;
        alu_c = 1'b0;
        alu_o = 1'b0;
        known = 1'b1;
        case (s1_op)
            OP_ADD: begin
                ext   = {1'b0, opa} + {1'b0, opb};
                alu_r = ext[W-1:0];
                alu_c = ext[W];
                alu_o = (opa[W-1] == opb[W-1]) && (alu_r[W-1] != opa[W-1]);
            end
            OP_SUB: begin
                alu_r = opa - opb;
                alu_c = opa < opb;
                alu_o = (opa[W-1] != opb[W-1]) && (alu_r[W-1] != opa[W-1]);
            end
            OP_AND: alu_r = opa & opb;
            OP_OR:  alu_r = opa | opb;
            OP_XOR: alu_r = opa ^ opb;
            OP_SHL: begin
                ext   = {1'b0, opa} << sh;
                alu_r = ext[W-1:0];
                alu_c = ext[W];
            end
            OP_SHR: begin
                ext   = {opa, 1'b0} >> sh;
                alu_r = ext[W:1];
                alu_c = ext[0];
            end
            OP_SAR: begin
                ext   = $signed({opa, 1'b0}) >>> sh;
                alu_r = ext[W:1];
                alu_c = ext[0];
            end
            default: known = 1'b0;
        endcase
    end

endmodule

// File: rtl/fu_alu_cluster.sv
// Integer execution cluster: NLANE ALU lanes plus a pipelined multiplier that
// shares lane MUL_LANE's writeback port through a slot-reservation shift register.
module fu_alu_cluster
    import alu_cluster_pkg::*;
#(
    parameter int NLANE    = 6,
    parameter int W        = 64,
    parameter int NFWD     = 10,
    parameter int MUL_LAT  = 4,
    parameter int MUL_LANE = NLANE - 1,
    parameter int RW       = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                except,
    input  logic [NLANE-1:0]    in_vld,
    input  logic [NLANE*8-1:0]  in_op,
    input  logic [NLANE*W-1:0]  in_A,
    input  logic [NLANE*W-1:0]  in_B,
    input  logic [NLANE*RW-1:0] in_tag,
    input  logic [NLANE*NFWD-1:0] A_fwd,
    input  logic [NLANE*NFWD-1:0] B_fwd,
    input  logic [NLANE*NFWD-1:0] A_fwdr,
    input  logic [NLANE*NFWD-1:0] B_fwdr,
    input  logic [NFWD*W-1:0]   fwd_bus,
    output logic [NLANE-1:0]    res_vld,
    output logic [NLANE*W-1:0]  res_data,
    output logic [NLANE*4-1:0]  res_flg,
    output logic [NLANE*RW-1:0] res_tag,
    output logic                mul_slot_blk,
    output logic                coll_err
);

    logic [NFWD*W-1:0] fwd_bus_r;
    logic [MUL_LAT-1:0] resv;

    logic              lane_vld    [NLANE];
    logic [W-1:0]      lane_data   [NLANE];
    logic [3:0]        lane_flg    [NLANE];
    logic [RW-1:0]     lane_tag    [NLANE];
    logic              lane_simple [NLANE];
    logic              lane_mul    [NLANE];
    logic [W-1:0]      lane_opa    [NLANE];
    logic [W-1:0]      lane_opb    [NLANE];
    logic [RW-1:0]     lane_otag   [NLANE];

    logic              mul_v [MUL_LAT];
    logic [W-1:0]      mul_d [MUL_LAT];
    logic [3:0]        mul_f [MUL_LAT];
    logic [RW-1:0]     mul_t [MUL_LAT];

    logic [2*W-1:0]    prod;
    logic              issue_mul;
    logic              kill;

    assign issue_mul    = in_vld[MUL_LANE] && (in_op[MUL_LANE*8 +: 8] == OP_MUL);
    assign mul_slot_blk = resv[MUL_LAT-2];
    // The oldest reservation bit lines up with the simple op now in the lane's issue stage.
    assign kill         = resv[MUL_LAT-1] & lane_simple[MUL_LANE];
    assign prod         = {{W{1'b0}}, lane_opa[MUL_LANE]} * {{W{1'b0}}, lane_opb[MUL_LANE]};

    for (genvar i = 0; i < NLANE; i++) begin : g_lane
        alu_lane #(
            .W       (W),
            .NFWD    (NFWD),
            .RW      (RW),
            .HAS_MUL (i == MUL_LANE)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .except     (except),
            .in_vld     (in_vld[i]),
            .in_op      (in_op[i*8 +: 8]),
            .in_a       (in_A[i*W +: W]),
            .in_b       (in_B[i*W +: W]),
            .in_tag     (in_tag[i*RW +: RW]),
            .a_fwd      (A_fwd[i*NFWD +: NFWD]),
            .b_fwd      (B_fwd[i*NFWD +: NFWD]),
            .a_fwdr     (A_fwdr[i*NFWD +: NFWD]),
            .b_fwdr     (B_fwdr[i*NFWD +: NFWD]),
            .fwd_bus    (fwd_bus),
            .fwd_bus_r  (fwd_bus_r),
            .kill       ((i == MUL_LANE) ? kill : 1'b0),
            .res_vld    (lane_vld[i]),
            .res_data   (lane_data[i]),
            .res_flg    (lane_flg[i]),
            .res_tag    (lane_tag[i]),
            .simple_vld (lane_simple[i]),
            .mul_vld    (lane_mul[i]),
            .opa        (lane_opa[i]),
            .opb        (lane_opb[i]),
            .tag        (lane_otag[i])
        );

        if (i == MUL_LANE) begin : g_merge
            assign res_vld[i]          = lane_vld[i] | mul_v[MUL_LAT-1];
            assign res_data[i*W +: W]  = mul_v[MUL_LAT-1] ? mul_d[MUL_LAT-1] : lane_data[i];
            assign res_flg[i*4 +: 4]   = mul_v[MUL_LAT-1] ? mul_f[MUL_LAT-1] : lane_flg[i];
            assign res_tag[i*RW +: RW] = mul_v[MUL_LAT-1] ? mul_t[MUL_LAT-1] : lane_tag[i];
        end else begin : g_direct
            assign res_vld[i]          = lane_vld[i];
            assign res_data[i*W +: W]  = lane_data[i];
            assign res_flg[i*4 +: 4]   = lane_flg[i];
            assign res_tag[i*RW +: RW] = lane_tag[i];
        end
    end

    // Product and flags are formed in the first stage, later stages only carry them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_bus_r <= '0;
            resv      <= '0;
            coll_err  <= 1'b0;
            for (int k = 0; k < MUL_LAT; k++) begin
                mul_v[k] <= 1'b0;
                mul_d[k] <= '0;
                mul_f[k] <= '0;
                mul_t[k] <= '0;
            end
        end else begin
            fwd_bus_r <= fwd_bus;
            mul_d[0]  <= prod[W-1:0];
            mul_f[0]  <= mk_flg(|prod[2*W-1:W], prod[W-1], prod[W-1:0] == '0, |prod[2*W-1:W]);
            mul_t[0]  <= lane_otag[MUL_LANE];
            for (int k = 1; k < MUL_LAT; k++) begin
                mul_d[k] <= mul_d[k-1];
                mul_f[k] <= mul_f[k-1];
                mul_t[k] <= mul_t[k-1];
            end
            if (except) begin
                resv     <= '0;
                coll_err <= 1'b0;
                for (int k = 0; k < MUL_LAT; k++) mul_v[k] <= 1'b0;
            end else begin
                resv     <= {resv[MUL_LAT-2:0], issue_mul};
                coll_err <= kill;
                mul_v[0] <= lane_mul[MUL_LANE];
                for (int k = 1; k < MUL_LAT; k++) mul_v[k] <= mul_v[k-1];
            end
        end
    end

endmodule

// File: doc/fu_alu_cluster.md
# fu_alu_cluster

- Parametrised integer execution cluster: NLANE single-cycle ALU lanes plus one pipelined multiplier that shares lane MUL_LANE's writeback port.
- Each lane takes operands from a register-read value, a current-cycle forwarding bus or a previous-cycle forwarding bus.
- It sits between the integer scheduler and the writeback/forwarding network.
- It generalises the fixed six-lane ALU group with width/lane/bus parameters, flush, and explicit multiplier writeback-slot reservation with collision reporting.

## Interface
- NLANE, 6, number of ALU lanes
- W, 64, data width (power of two, ≥8)
- NFWD, 10, number of forwarding buses
- MUL_LAT, 4, multiplier pipeline stages (≥2)
- MUL_LANE, NLANE-1, lane whose writeback port the multiplier shares
- RW, 9, result tag width
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- except  in  1  flush; kills all in-flight work
- in_vld  in  NLANE  issue valid per lane
- in_op  in  NLANE*8  opcode per lane
- in_A, in_B  in  NLANE*W  register-read operands
- in_tag  in  NLANE*RW  destination tag
- A_fwd, B_fwd  in  NLANE*NFWD  one-hot select: current-cycle fwd_bus
- A_fwdr, B_fwdr  in  NLANE*NFWD  one-hot select: previous-cycle fwd_bus
- fwd_bus  in  NFWD*W  machine-wide forwarding buses
- res_vld  out  NLANE  result valid
- res_data  out  NLANE*W  result
- res_flg  out  NLANE*4  flags {O,S,Z,C}
- res_tag  out  NLANE*RW  tag of result
- mul_slot_blk  out  1  do not issue a non-MUL op to MUL_LANE this cycle
- coll_err  out  1  pulse: non-MUL op on MUL_LANE was dropped

## Operation
- Ops: ADD, SUB, AND, OR, XOR, SHL, SHR, SAR, MUL. Unknown opcode: result 0, flags 0, res_vld still asserted.
- Operand select per operand: current-bus select (any bit set) wins over registered-bus select. If both are zero, the register-read value is used. More than one bit set in a select is illegal and is asserted in simulation.
- Arithmetic is modulo 2^W.
  - ADD: C = carry out, O = signed overflow.
  - SUB: C = borrow (A<B unsigned), O = signed overflow.
  - AND/OR/XOR: C = O = 0.
- Shifts: amount = B[log2(W)-1:0]. SAR is sign-filling. C = last bit shifted out, or 0 for amount 0. O = 0.
- Z and S for every op are derived from the W-bit result.
- MUL is accepted on MUL_LANE only; MUL on any other lane produces the unknown-opcode result.
  - Result is the unsigned product low W bits.
  - C = O = (high W bits ≠ 0).
  - Back-to-back MULs are fully pipelined.
- Slot reservation: a MUL issued in cycle t occupies MUL_LANE's writeback in cycle t+1+MUL_LAT. That is the same writeback cycle as a simple op issued in t+MUL_LAT-1.
  - A MUL_LAT-bit shift register tracks reservations.
  - mul_slot_blk is high in exactly those conflicting issue cycles.
  - If a non-MUL op is issued to MUL_LANE while mul_slot_blk=1, the MUL wins the port. The simple op is dropped and coll_err pulses in its would-be writeback cycle.
- except sampled high at an edge clears every valid bit in the lane stages, the multiplier stages and the reservation register. Issues presented in the same cycle are also dropped. Forwarding registers are not affected.

## Timing
- Cycle t: issue inputs registered.
- Cycle t+1: operand mux uses fwd_bus(t+1) or the registered fwd_bus(t); ALU evaluates; result registered.
- Cycle t+2: simple-op res_* visible. Latency 2.
- MUL: res_* visible in t+1+MUL_LAT on MUL_LANE.
- mul_slot_blk is combinational from the reservation register and has no input-to-output path.
- Reset values: res_vld=0, res_data=0, res_flg=0, res_tag=0, mul_slot_blk=0, coll_err=0. All pipeline valids, reservations and fwd_bus registers clear.
- Reset asserted mid-operation discards all in-flight work immediately.

## Structure
- Package alu_cluster_pkg:
  - opcode constants OP_ADD..OP_MUL;
  - flag bit indices FLG_C=0, FLG_Z=1, FLG_S=2, FLG_O=3.
- Sub-module alu_lane: operand forwarding mux plus single-cycle ALU and result register. Instantiated NLANE times by generate.
- Multiplier pipeline, reservation register and writeback merge for MUL_LANE live in the top module.

## Test plan
- Reset: hold rst, then release → all outputs 0. Issue ADD lane0, A=5, B=7, tag=3 at t → at t+2 res_vld[0]=1, data=12, flg=0, tag=3.
- Flags: SUB A=0, B=1 → data=all-ones, C=1, S=1. ADD 0x7FFF…F + 1 → O=1, S=1. SAR 0x8000…0 by 63 → all-ones.
- Forwarding: issue at t with A_fwd[lane1]=bus2 while fwd_bus2(t+1)=0x10 → ADD B=1 gives 0x11. Same with A_fwdr: bus value at t used. With both selects set, A_fwd wins.
- MUL: MUL 0x1_0000_0000 × 0x1_0000_0000 (W=64) → data=0, C=O=1, Z=1 at t+5 (MUL_LAT=4). Three back-to-back MULs → three consecutive results.
- Collision: MUL at t → mul_slot_blk=1 at t+3 only. ADD to MUL_LANE at t+3 → MUL result at t+5, coll_err=1 at t+5, ADD lost.
- Flush: MUL at t, ADD at t+1, except at t+2 → no res_vld for either, mul_slot_blk low from t+3. New ADD at t+3 completes normally at t+5.
